fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage upstream of decode/immediate extension. Holds the PC, issues one
//  word read at a time to instruction memory, and presents the fetched word to decode through
//  a valid/ready instruction register. Decode feeds ir_instr[23:0] to the immediate extender.
//  Taken branches redirect the PC to br_pc + BR_OFFSET + ext_imm, where ext_imm is the extender output.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded at reset; bits [1:0] must be 0
//  BR_OFFSET  32'd8          pipeline PC bias added to branch targets (ARM PC+8)
// PORTS
//  clk          in   1   clock; all state changes on the rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  imem_req     out  1   read request; held high until imem_gnt
//  imem_addr    out  32  word address; always equals pc, bits [1:0] are 0
//  imem_gnt     in   1   memory accepts the request this cycle
//  imem_rvalid  in   1   read data valid; at most one per granted request, at least 1 cycle after gnt
//  imem_rdata   in   32  read data
//  ir_valid     out  1   ir_instr/ir_pc hold a valid instruction
//  ir_ready     in   1   decode consumes the instruction when ir_valid & ir_ready
//  ir_instr     out  32  fetched instruction
//  ir_pc        out  32  address ir_instr was fetched from
//  br_taken     in   1   single-cycle redirect pulse from execute
//  br_pc        in   32  PC of the branch instruction
//  ext_imm      in   32  sign-extended, <<2 branch offset from the extender
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; pc=RESET_PC; ir_valid=0; ir_instr=0; ir_pc=0;
//   imem_req=0. imem_addr=pc. Requests start one cycle after reset_n deasserts.
//  imem_req = (state==FETCH); ir_valid is registered.
//  Target = br_pc + BR_OFFSET + ext_imm, modulo 2^32 with no overflow detection; pc[1:0] is forced to 00.
//  States and transitions (br_taken overrides every row):
//   IDLE  -> FETCH unconditionally.
//   FETCH : gnt -> WAIT; otherwise stay.
//   WAIT  : rvalid -> ir_instr=rdata, ir_pc=pc, pc=pc+4, ir_valid=1 -> HOLD.
//   HOLD  : ir_valid & ir_ready -> ir_valid=0 -> FETCH; otherwise hold all IR outputs stable.
//   DROP  : rvalid -> discard the data, pc unchanged -> FETCH.
//  br_taken in any state loads pc=target and clears ir_valid next cycle. Next state:
//   DROP if state is WAIT or DROP, or FETCH with gnt in the same cycle (a read is outstanding).
//   FETCH otherwise, including IDLE.
//   A br_taken in DROP only reloads pc, so the last redirect wins.
//  br_taken with ir_valid & ir_ready in the same cycle: the transfer counts for decode;
//   the fetch unit still clears ir_valid.
//  br_taken and rvalid in the same cycle in WAIT: the data is discarded and no IR load occurs.
//   No further rvalid arrives, so the next state is FETCH, not DROP.
//  PC wrap: pc=32'hFFFF_FFFC +4 -> 32'h0000_0000.
//  Throughput: one outstanding request; 3 cycles minimum per instruction with gnt/rvalid back-to-back.
//  Reset mid-operation: all state returns to reset values immediately. A pending rvalid after
//   release is ignored because the state is IDLE.
// STRUCTURE
//  fetch_pkg: fetch_state_e {IDLE,FETCH,WAIT,HOLD,DROP}, PC_STEP=32'd4, default BR_OFFSET, RESET_PC.
//  Single module; the target adder and the pc+4 adder are inline. No sub-module.
// TESTING
//  1 Reset, gnt tied 1, rvalid 1 cycle after gnt, ir_ready=1
//    -> imem_addr sequence 0,4,8; ir_pc matches; first ir_valid 3 cycles after release.
//  2 ir_ready=0 for 5 cycles in HOLD
//    -> ir_instr/ir_pc stable; imem_req=0; no pc change.
//  3 br_taken in HOLD, br_pc=0x100, ext_imm=0xFFFF_FFF8
//    -> ir_valid=0 next cycle; next imem_addr=0x100.
//  4 br_taken while in WAIT (br_pc=0x20, ext_imm=0x40)
//    -> following rvalid discarded (ir_valid stays 0); next imem_addr=0x68.
//  5 br_taken coincident with gnt, then rvalid
//    -> data dropped; fetch resumes at target; same-cycle br_taken+rvalid in WAIT -> no IR load, FETCH.
//  6 reset_n asserted in WAIT with rvalid pending
//    -> outputs reset asynchronously; after release the first request goes to RESET_PC; stale rvalid ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
`timescale 1ns/1ps
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP           = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_BR_OFFSET = 32'd8;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    DROP
  } fetch_state_e;

  // Instruction register payload handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ir_entry_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word read at a time to
// instruction memory and presents the fetched word to decode through a
// valid/ready instruction register. Taken branches redirect the PC to
// br_pc + BR_OFFSET + ext_imm.
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   imem_req/addr/gnt      read request handshake (addr is always pc)
//   imem_rvalid/rdata      read return, one per granted request
//   ir_valid/ready         instruction register handshake to decode
//   ir_instr/ir_pc         fetched word and the address it came from
//   br_taken/br_pc/ext_imm single-cycle redirect from execute
`timescale 1ns/1ps
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] BR_OFFSET = DEFAULT_BR_OFFSET
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [XLEN-1:0] ir_instr,
  output logic [XLEN-1:0] ir_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] ext_imm
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] target_c;
  ir_entry_t       ir, ir_n;
  logic            ir_valid_n;
  logic            imem_req_n;
  logic            outstanding_c;

  assign imem_addr = pc;
  assign ir_instr  = ir.instr;
  assign ir_pc     = ir.pc;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
      imem_req <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      ir_valid <= ir_valid_n;
      imem_req <= imem_req_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    ir_n          = ir;
    ir_valid_n    = ir_valid;
    target_c      = br_pc + BR_OFFSET + ext_imm;
    // A read is still in flight after this cycle: either one already
    // outstanding that does not return now, or one granted this cycle.
    outstanding_c = (((state == WAIT) || (state == DROP)) && !imem_rvalid) ||
                    ((state == FETCH) && imem_gnt);

    unique case (state)
      IDLE:  state_n = FETCH;
      FETCH: if (imem_gnt) state_n = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          ir_n.instr = imem_rdata;
          ir_n.pc    = pc;
          pc_n       = pc + PC_STEP;
          ir_valid_n = 1'b1;
          state_n    = HOLD;
        end
      end
      HOLD: begin
        if (ir_valid && ir_ready) begin
          ir_valid_n = 1'b0;
          state_n    = FETCH;
        end
      end
      DROP:  if (imem_rvalid) state_n = FETCH;
      default: state_n = IDLE;
    endcase

    // Redirect overrides everything: no IR load, in-flight data is dropped.
    if (br_taken) begin
      pc_n       = target_c & ~32'd3;
      ir_n       = ir;
      ir_valid_n = 1'b0;
      state_n    = outstanding_c ? DROP : FETCH;
    end

    imem_req_n = (state_n == FETCH);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a memory model answers requests
// with random grant/latency, the driver issues random stalls and redirects,
// and a monitor checks every instruction consumed by decode against the
// expected program-order stream.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] BR_OFS = 32'd8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic [31:0] ir_instr;
  logic [31:0] ir_pc;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = '0;
  logic [31:0] ext_imm = '0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc),
    .br_taken(br_taken), .br_pc(br_pc), .ext_imm(ext_imm)
  );

  int tests = 0;
  int fails = 0;
  int hs_count = 0;
  int idle_cnt = 0;

  ir_entry_t exp_q[$];
  ir_entry_t mon_e;

  // Memory model state
  bit          fast = 1'b1;
  bit          busy = 1'b0;
  bit          stale = 1'b0;
  int          lat = 0;
  logic [31:0] addr_q = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic ir_entry_t exp_entry(input logic [31:0] a);
    ir_entry_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: random grant, 1..3 cycle return latency.
  always @(negedge clk) begin
    if (!reset_n) begin
      if (busy) stale = 1'b1;
      busy        = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (stale) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        stale       = 1'b0;
      end else if (busy) begin
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(addr_q);
          busy        = 1'b0;
        end else begin
          lat--;
        end
      end else if (imem_req && (fast || $urandom_range(0, 2) != 0)) begin
        imem_gnt = 1'b1;
        busy     = 1'b1;
        addr_q   = imem_addr;
        lat      = fast ? 0 : int'($urandom_range(0, 2));
      end
    end
  end

  // Monitor: compares every decode handshake against the scoreboard.
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      idle_cnt++;
      if (ir_valid) check("no_req_while_valid", 32'(imem_req), 32'd0);
      if (imem_req) check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
      if (ir_valid && ir_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty: got pc %h expected no instruction", ir_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("ir_pc", ir_pc, mon_e.pc);
          check("ir_instr", ir_instr, mon_e.instr);
          exp_q.push_back(exp_entry(mon_e.pc + 32'd4));
        end
        hs_count++;
        idle_cnt = 0;
      end
      if (idle_cnt > 80) begin
        tests++;
        fails++;
        $display("FAIL watchdog: got %0d idle cycles expected at most 80", idle_cnt);
        idle_cnt = 0;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
    check({tag, "_ir_instr"}, ir_instr, 32'd0);
    check({tag, "_ir_pc"}, ir_pc, 32'd0);
    check({tag, "_imem_addr"}, imem_addr, RST_PC);
  endtask

  task automatic random_cycles(input int n);
    logic [31:0] r;
    logic [31:0] tgt;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ir_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 11) == 0) begin
        br_taken = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          br_pc   = 32'hFFFF_FFF0;
          ext_imm = 32'hFFFF_FFFC;
        end else begin
          r       = $urandom();
          br_pc   = r & ~32'd3;
          r       = $urandom();
          ext_imm = {{6{r[23]}}, r[23:0], 2'b00};
        end
      end else begin
        br_taken = 1'b0;
      end
      #2;
      if (br_taken) begin
        tgt = (br_pc + BR_OFS + ext_imm) & ~32'd3;
        exp_q.delete();
        exp_q.push_back(exp_entry(tgt));
      end
    end
    @(negedge clk);
    br_taken = 1'b0;
  endtask

  initial begin
    int guard;
    exp_q.push_back(exp_entry(RST_PC));
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Back-to-back timing from reset release.
    @(posedge clk); #1 check("first_valid_e1", 32'(ir_valid), 32'd0);
    check("first_req_e1", 32'(imem_req), 32'd1);
    @(posedge clk); #1 check("first_valid_e2", 32'(ir_valid), 32'd0);
    @(posedge clk); #1 check("first_valid_e3", 32'(ir_valid), 32'd1);
    check("first_ir_pc", ir_pc, RST_PC);
    check("pc_after_first", imem_addr, RST_PC + 32'd4);
    repeat (12) @(posedge clk);

    fast = 1'b0;
    random_cycles(1500);

    // Reset while a read is outstanding.
    guard = 0;
    do begin
      @(negedge clk);
      br_taken = 1'b0;
      #2;
      guard++;
    end while (!busy && guard < 200);
    check("busy_before_reset", 32'(busy), 32'd1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(exp_entry(RST_PC));
    #1 check_reset_values("mid");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1 check("post_reset_req", 32'(imem_req), 32'd1);
    check("post_reset_addr", imem_addr, RST_PC);
    check("post_reset_valid", 32'(ir_valid), 32'd0);

    random_cycles(1500);

    check("handshakes_seen", 32'(hs_count > 200), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
